// File: rtl/qr_pkg.sv
// Shared sizing and helpers for the QR result reorder buffer.
package qr_pkg;

  localparam int unsigned ROWS        = 8;
  localparam int unsigned COLS        = 4;
  localparam int unsigned DATA_WIDTH  = 12;
  localparam int unsigned R_TRI       = COLS * (COLS + 1) / 2;
  localparam int unsigned FRAME_BEATS = ROWS * COLS;
  localparam int unsigned OUT_BEATS   = R_TRI + FRAME_BEATS;

  // Kind of element currently presented on the output.
  typedef enum logic {
    ELEM_R = 1'b0,
    ELEM_Q = 1'b1
  } elem_kind_e;

  // Packed row-major index of R[row][col] in the upper triangle (col >= row).
  // Rows above 'row' hold ncols + (ncols-1) + ... entries.
  function automatic int unsigned tri_index(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned ncols);
    return (row * (2 * ncols - row + 1)) / 2 + (col - row);
  endfunction

endpackage

// File: rtl/qr_result_reorder_if.sv
// Engine-side input stream and consumer-side output stream of the reorder buffer.
interface qr_result_reorder_if
  import qr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = qr_pkg::DATA_WIDTH
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_q;
  logic [DATA_WIDTH-1:0] in_r;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_is_q;
  logic                  out_last;
  logic                  err_overflow;

  // Reorder buffer side.
  modport slave (
    input  in_valid, in_q, in_r, out_ready,
    output out_valid, out_data, out_is_q, out_last, err_overflow
  );

  // Engine / consumer side.
  modport master (
    output in_valid, in_q, in_r, out_ready,
    input  out_valid, out_data, out_is_q, out_last, err_overflow
  );

endinterface

// File: rtl/qr_frame_bank.sv
// One ping-pong bank: R upper-triangle and Q storage plus its full flag.
module qr_frame_bank #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned R_WORDS    = 10,
  parameter int unsigned Q_WORDS    = 32,
  localparam int unsigned RAW       = $clog2(R_WORDS),
  localparam int unsigned QAW       = $clog2(Q_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_r_we,
  input  logic [RAW-1:0]        i_r_waddr,
  input  logic [DATA_WIDTH-1:0] i_r_wdata,
  input  logic                  i_q_we,
  input  logic [QAW-1:0]        i_q_waddr,
  input  logic [DATA_WIDTH-1:0] i_q_wdata,
  input  logic [RAW-1:0]        i_r_raddr,
  input  logic [QAW-1:0]        i_q_raddr,
  output logic [DATA_WIDTH-1:0] o_r_rdata,
  output logic [DATA_WIDTH-1:0] o_q_rdata,
  input  logic                  i_set_full,
  input  logic                  i_clr_full,
  output logic                  o_full
);

  logic [DATA_WIDTH-1:0] r_rmem [R_WORDS];
  logic [DATA_WIDTH-1:0] r_qmem [Q_WORDS];
  logic                  r_full;

  // Element storage; contents are only observed while the bank is full.
  always_ff @(posedge clk) begin
    if (i_r_we) r_rmem[i_r_waddr] <= i_r_wdata;
    if (i_q_we) r_qmem[i_q_waddr] <= i_q_wdata;
  end

  // Full flag: set by the last written beat, cleared by the last drained element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
    end else if (i_set_full) begin
      r_full <= 1'b1;
    end else if (i_clr_full) begin
      r_full <= 1'b0;
    end
  end

  // Asynchronous read ports, guarded against addresses past the array end.
  always_comb begin
    o_r_rdata = '0;
    o_q_rdata = '0;
    if (32'(i_r_raddr) < R_WORDS) o_r_rdata = r_rmem[i_r_raddr];
    if (32'(i_q_raddr) < Q_WORDS) o_q_rdata = r_qmem[i_q_raddr];
  end

  assign o_full = r_full;

endmodule

// File: rtl/qr_result_reorder.sv
// Captures Q/R frames from the CORDIC engine into two ping-pong banks and
// re-emits each as the R upper triangle (row-major) followed by Q (row-major).
module qr_result_reorder
  import qr_pkg::*;
#(
  parameter int unsigned ROWS       = qr_pkg::ROWS,
  parameter int unsigned COLS       = qr_pkg::COLS,
  parameter int unsigned DATA_WIDTH = qr_pkg::DATA_WIDTH
) (
  input logic                clk,
  input logic                rst,
  qr_result_reorder_if.slave bus
);

  localparam int unsigned L_R_TRI = COLS * (COLS + 1) / 2;
  localparam int unsigned L_R_SQ  = COLS * COLS;
  localparam int unsigned L_FRAME = ROWS * COLS;
  localparam int unsigned L_OUT   = L_R_TRI + L_FRAME;
  localparam int unsigned WCW     = $clog2(L_FRAME);
  localparam int unsigned RCW     = $clog2(L_OUT);
  localparam int unsigned TAW     = $clog2(L_R_TRI);
  localparam int unsigned QAW     = $clog2(L_FRAME);

  // Write side state
  logic [WCW-1:0] r_wr_cnt;
  logic           r_wr_bank;
  logic           r_drop;
  logic           r_err;

  // Read side state
  logic [RCW-1:0] r_rd_cnt;
  logic           r_rd_bank;

  // Write side decode
  int unsigned    w_beat;
  int unsigned    w_q_row;
  int unsigned    w_q_col;
  int unsigned    w_r_row;
  int unsigned    w_r_col;
  logic           w_first;
  logic           w_last_beat;
  logic           w_drop;
  logic           w_wr_en;
  logic           w_r_we;
  logic           w_q_we;
  logic [TAW-1:0] w_r_waddr;
  logic [QAW-1:0] w_q_waddr;
  logic           w_frame_done;
  logic [1:0]     w_set_full;

  // Read side decode
  logic [1:0]            w_full;
  logic [1:0]            w_clr_full;
  logic                  w_out_valid;
  logic                  w_xfer;
  logic                  w_rd_last;
  elem_kind_e            w_kind;
  logic [TAW-1:0]        w_rd_r_addr;
  logic [QAW-1:0]        w_rd_q_addr;
  logic [DATA_WIDTH-1:0] w_r_rdata0;
  logic [DATA_WIDTH-1:0] w_r_rdata1;
  logic [DATA_WIDTH-1:0] w_q_rdata0;
  logic [DATA_WIDTH-1:0] w_q_rdata1;
  logic [DATA_WIDTH-1:0] w_sel_r;
  logic [DATA_WIDTH-1:0] w_sel_q;

  // Beat decode: Q arrives column-major and is stored row-major; only the
  // upper triangle of the row-major R beats is kept.
  always_comb begin
    w_beat      = 32'(r_wr_cnt);
    w_q_row     = w_beat % ROWS;
    w_q_col     = w_beat / ROWS;
    w_r_row     = w_beat / COLS;
    w_r_col     = w_beat % COLS;
    w_first     = (r_wr_cnt == '0);
    w_last_beat = (w_beat == L_FRAME - 1);
    // Drop decision is taken on beat 0 from the registered full flag and held.
    w_drop      = w_first ? w_full[r_wr_bank] : r_drop;
    w_wr_en     = bus.in_valid && !w_drop;
    w_q_we      = w_wr_en;
    w_q_waddr   = QAW'(w_q_row * COLS + w_q_col);
    w_r_we      = w_wr_en && (w_beat < L_R_SQ) && (w_r_col >= w_r_row);
    w_r_waddr   = TAW'(tri_index(w_r_row, w_r_col, COLS));
    w_frame_done  = bus.in_valid && w_last_beat && !w_drop;
    w_set_full[0] = w_frame_done && (r_wr_bank == 1'b0);
    w_set_full[1] = w_frame_done && (r_wr_bank == 1'b1);
  end

  // Input beat counter, drop latch, write bank pointer and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
      r_drop    <= 1'b0;
      r_err     <= 1'b0;
    end else if (bus.in_valid) begin
      r_drop <= w_drop;
      if (w_first && w_drop) r_err <= 1'b1;
      if (w_last_beat) begin
        r_wr_cnt <= '0;
        if (!w_drop) r_wr_bank <= ~r_wr_bank;
      end else begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
    end
  end

  // Output element decode: index 0..R_TRI-1 reads R, the rest reads Q.
  always_comb begin
    w_out_valid   = w_full[r_rd_bank];
    w_xfer        = w_out_valid && bus.out_ready;
    w_rd_last     = (32'(r_rd_cnt) == L_OUT - 1);
    w_kind        = (32'(r_rd_cnt) < L_R_TRI) ? ELEM_R : ELEM_Q;
    w_rd_r_addr   = TAW'(r_rd_cnt);
    w_rd_q_addr   = QAW'(r_rd_cnt - RCW'(L_R_TRI));
    w_clr_full[0] = w_xfer && w_rd_last && (r_rd_bank == 1'b0);
    w_clr_full[1] = w_xfer && w_rd_last && (r_rd_bank == 1'b1);
    w_sel_r       = r_rd_bank ? w_r_rdata1 : w_r_rdata0;
    w_sel_q       = r_rd_bank ? w_q_rdata1 : w_q_rdata0;
  end

  // Output element counter and read bank pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else if (w_xfer) begin
      if (w_rd_last) begin
        r_rd_cnt  <= '0;
        r_rd_bank <= ~r_rd_bank;
      end else begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
    end
  end

  // Output mux; outputs are forced to zero whenever nothing is presented.
  always_comb begin
    bus.out_valid    = w_out_valid;
    bus.out_data     = '0;
    bus.out_is_q     = 1'b0;
    bus.out_last     = 1'b0;
    bus.err_overflow = r_err;
    if (w_out_valid) begin
      bus.out_data = (w_kind == ELEM_R) ? w_sel_r : w_sel_q;
      bus.out_is_q = (w_kind == ELEM_Q);
      bus.out_last = w_rd_last;
    end
  end

  qr_frame_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .R_WORDS    (L_R_TRI),
    .Q_WORDS    (L_FRAME)
  ) u_bank0 (
    .clk        (clk),
    .rst        (rst),
    .i_r_we     (w_r_we && (r_wr_bank == 1'b0)),
    .i_r_waddr  (w_r_waddr),
    .i_r_wdata  (bus.in_r),
    .i_q_we     (w_q_we && (r_wr_bank == 1'b0)),
    .i_q_waddr  (w_q_waddr),
    .i_q_wdata  (bus.in_q),
    .i_r_raddr  (w_rd_r_addr),
    .i_q_raddr  (w_rd_q_addr),
    .o_r_rdata  (w_r_rdata0),
    .o_q_rdata  (w_q_rdata0),
    .i_set_full (w_set_full[0]),
    .i_clr_full (w_clr_full[0]),
    .o_full     (w_full[0])
  );

  qr_frame_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .R_WORDS    (L_R_TRI),
    .Q_WORDS    (L_FRAME)
  ) u_bank1 (
    .clk        (clk),
    .rst        (rst),
    .i_r_we     (w_r_we && (r_wr_bank == 1'b1)),
    .i_r_waddr  (w_r_waddr),
    .i_r_wdata  (bus.in_r),
    .i_q_we     (w_q_we && (r_wr_bank == 1'b1)),
    .i_q_waddr  (w_q_waddr),
    .i_q_wdata  (bus.in_q),
    .i_r_raddr  (w_rd_r_addr),
    .i_q_raddr  (w_rd_q_addr),
    .o_r_rdata  (w_r_rdata1),
    .o_q_rdata  (w_q_rdata1),
    .i_set_full (w_set_full[1]),
    .i_clr_full (w_clr_full[1]),
    .o_full     (w_full[1])
  );

endmodule

// File: tb/tb_qr_result_reorder.sv
// Directed bench for qr_result_reorder: frame tags distinguish frames,
// tag 0 carries Q[i][j]=16*i+j and R[i][j]=0x100+4*i+j.
module tb_qr_result_reorder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Row/column of each output R element, upper triangle row-major.
  int tri_row [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
  int tri_col [10] = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3};

  qr_result_reorder_if #(.DATA_WIDTH(12)) bus ();

  qr_result_reorder #(
    .ROWS       (8),
    .COLS       (4),
    .DATA_WIDTH (12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [11:0] q_val(input int tag, input int i, input int j);
    return 12'((tag << 8) + 16 * i + j);
  endfunction

  function automatic logic [11:0] r_val(input int tag, input int i, input int j);
    return 12'(32'h100 + (tag << 9) + 4 * i + j);
  endfunction

  // {is_q, last, data} expected for output element n of a frame.
  function automatic logic [13:0] exp_elem(input int tag, input int n);
    logic last;
    last = (n == 41);
    if (n < 10) return {1'b0, last, r_val(tag, tri_row[n], tri_col[n])};
    return {1'b1, last, q_val(tag, (n - 10) / 4, (n - 10) % 4)};
  endfunction

  task automatic check_outputs_zero(input string name);
    chk({name, "_valid"}, 32'(bus.out_valid), 0);
    chk({name, "_data"},  32'(bus.out_data),  0);
    chk({name, "_is_q"},  32'(bus.out_is_q),  0);
    chk({name, "_last"},  32'(bus.out_last),  0);
    chk({name, "_err"},   32'(bus.err_overflow), 0);
  endtask

  // Drives nbeats beats of a frame, column-major Q, lower-triangle R = 0xFFF.
  task automatic send_frame(input int tag, input int nbeats, input bit gaps, input bit chk_lat);
    int unsigned g;
    for (int k = 0; k < nbeats; k++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        for (int unsigned s = 0; s < g; s++) begin
          bus.in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_q     = q_val(tag, k % 8, k / 8);
      bus.in_r     = (k < 16 && (k % 4) >= (k / 4)) ? r_val(tag, k / 4, k % 4) : 12'hFFF;
      if (chk_lat && k == nbeats - 1) begin
        @(negedge clk);
        chk("latency_before_last", 32'(bus.out_valid), 0);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (chk_lat) chk("latency_t_plus_1", 32'(bus.out_valid), 1);
  endtask

  // Accepts count elements of frame 'tag'. rand_ready toggles out_ready;
  // contig 1 = no bubbles after the first element, 2 = none from the start.
  task automatic recv_frame(input int tag, input int count, input bit rand_ready, input int contig);
    int          n;
    int          cyc;
    bit          started;
    bit          prev_stall;
    logic [13:0] obs;
    logic [13:0] prev;
    n = 0; cyc = 0; started = (contig == 2); prev_stall = 1'b0; prev = '0;
    while (n < count && cyc < 600) begin
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      obs = {bus.out_is_q, bus.out_last, bus.out_data};
      if (contig != 0 && started) chk("contiguous", 32'(bus.out_valid), 1);
      if (prev_stall) begin
        chk("stall_valid_held", 32'(bus.out_valid), 1);
        chk("stall_data_held", 32'(obs), 32'(prev));
      end
      prev_stall = 1'b0;
      if (bus.out_valid) begin
        started = 1'b1;
        chk($sformatf("elem_t%0d_n%0d", tag, n), 32'(obs), 32'(exp_elem(tag, n)));
        chk("no_lower_tri", 32'(bus.out_data != 12'hFFF), 1);
        if (bus.out_ready) n++;
        else begin
          prev_stall = 1'b1;
          prev       = obs;
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    chk($sformatf("frame_t%0d_count", tag), 32'(n), 32'(count));
  endtask

  task automatic pulse_reset(input string name);
    rst = 1'b1;
    #1;
    check_outputs_zero(name);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_q      = '0;
    bus.in_r      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Single frame, consumer always ready, output at t+1
    bus.out_ready = 1'b1;
    send_frame(0, 32, 1'b0, 1'b1);
    recv_frame(0, 42, 1'b0, 2);
    @(negedge clk);
    chk("idle_after_single", 32'(bus.out_valid), 0);
    @(posedge clk); #1;

    // Two back-to-back frames, 84 contiguous elements
    fork
      begin
        send_frame(0, 32, 1'b0, 1'b0);
        send_frame(1, 32, 1'b0, 1'b0);
      end
      begin
        recv_frame(0, 42, 1'b0, 1);
        recv_frame(1, 42, 1'b0, 2);
      end
    join
    chk("no_overflow_two_frames", 32'(bus.err_overflow), 0);

    // Input gaps and random backpressure
    fork
      send_frame(0, 32, 1'b1, 1'b0);
      recv_frame(0, 42, 1'b1, 0);
    join
    bus.out_ready = 1'b1;

    // Reset after 16 input beats, then a fresh frame
    send_frame(2, 16, 1'b0, 1'b0);
    pulse_reset("rst_mid_frame");
    fork
      send_frame(1, 32, 1'b0, 1'b0);
      recv_frame(1, 42, 1'b0, 1);
    join

    // Reset mid-drain discards the undrained bank
    send_frame(2, 32, 1'b0, 1'b0);
    recv_frame(2, 10, 1'b0, 2);
    pulse_reset("rst_mid_drain");
    repeat (3) begin
      @(negedge clk);
      chk("drained_after_rst", 32'(bus.out_valid), 0);
    end
    @(posedge clk); #1;
    fork
      send_frame(3, 32, 1'b0, 1'b0);
      recv_frame(3, 42, 1'b0, 1);
    join
    chk("no_overflow_after_rst", 32'(bus.err_overflow), 0);

    // Three frames with consumer stalled: third is dropped
    bus.out_ready = 1'b0;
    send_frame(1, 32, 1'b0, 1'b0);
    send_frame(2, 32, 1'b0, 1'b0);
    chk("no_overflow_two_stored", 32'(bus.err_overflow), 0);
    send_frame(3, 32, 1'b0, 1'b0);
    chk("overflow_third_frame", 32'(bus.err_overflow), 1);
    recv_frame(1, 42, 1'b0, 2);
    recv_frame(2, 42, 1'b0, 2);
    repeat (4) begin
      @(negedge clk);
      chk("dropped_frame_absent", 32'(bus.out_valid), 0);
    end
    chk("overflow_sticky", 32'(bus.err_overflow), 1);
    @(posedge clk); #1;
    pulse_reset("rst_clears_overflow");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
